// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Imported by fetch_unit and its instruction buffer.
package fetch_unit_pkg;

  localparam int XLEN = 16;
  localparam logic [4:0] HALT_OPCODE = 5'b00000;
  localparam logic [XLEN-1:0] NOP_INSTR = 16'h0800;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fstate_e;

  typedef struct packed {
    word_t instr;
    word_t pc_plus2;
  } fetch_ent_t;

  function automatic logic is_halt(input word_t w);
    return w[15:11] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode.
// Holds {instr, pc_plus2} pairs; flush empties it in one cycle.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_ent_t    din,
  input  logic          pop,
  input  logic          flush,
  output fetch_ent_t    head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  fetch_ent_t    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wp] <= din;
  end

  assign head  = mem[rp];
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, single-outstanding imem reads,
// wrong-path squash on redirect and stop on HALT.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          BUF_DEPTH = 2,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  input  logic        imem_err,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  output logic        halted,
  output logic        err
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fstate_e       state;
  fstate_e       state_nxt;
  word_t         pc;
  word_t         addr_q;
  logic          outst;
  logic          drop;
  logic          req_q;
  logic          err_q;

  fetch_ent_t    head;
  fetch_ent_t    din;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  logic          resp;
  logic          push;
  logic          pop;
  logic          outst_nxt;
  logic          issue;

  assign resp = imem_valid && outst;
  assign push = resp && !drop && !redirect && (!full || pop);
  assign pop  = !empty && !stall && !redirect;
  assign din  = '{instr: imem_data, pc_plus2: addr_q + 16'd2};

  assign count_nxt = redirect ? '0
                   : count + CW'(push) - CW'(pop);
  assign outst_nxt = outst && !imem_valid;

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      redirect:                    state_nxt = FETCH;
      push && is_halt(imem_data):  state_nxt = HALTED;
      default: ;
    endcase
  end

  // Issue is decided on next-cycle state, so imem_req is a flop.
  assign issue = !redirect
              && state_nxt == FETCH
              && !outst_nxt
              && count_nxt < CW'(BUF_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
      outst  <= 1'b0;
      drop   <= 1'b0;
      req_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      req_q <= issue;
      outst <= outst_nxt || issue;
      if (redirect) drop <= outst && !imem_valid;
      else if (resp) drop <= 1'b0;
      if (redirect) begin
        pc <= {redirect_pc[15:1], 1'b0};
      end else if (issue) begin
        pc     <= pc + 16'd2;
        addr_q <= pc;
      end
      if ((imem_valid && (imem_err || !outst))
          || (redirect && redirect_pc[0]))
        err_q <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .flush (redirect),
    .head  (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = !empty;
  assign instr       = empty ? NOP_INSTR : head.instr;
  assign pc_plus2    = empty ? pc + 16'd2 : head.pc_plus2;
  assign halted      = (state == HALTED);
  assign err         = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable
// instruction memory and a decode-side capture of popped words.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_data = 16'h0;
  logic        imem_err = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic [15:0] instr;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic        halted;
  logic        err;

  int          nvec = 0;
  int          nerr = 0;
  int          lat = 1;
  logic [15:0] halt_addr = 16'hFFFF;
  logic [15:0] err_addr = 16'hFFFF;
  int          pend = 0;
  logic [15:0] paddr = 16'h0;
  logic [15:0] rq[$];
  logic [31:0] gq[$];

  fetch_unit #(
    .BUF_DEPTH (2),
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .imem_err    (imem_err),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .pc_plus2    (pc_plus2),
    .instr_valid (instr_valid),
    .halted      (halted),
    .err         (err)
  );

  always #10 clk = ~clk;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return (a == halt_addr) ? 16'h0000 : (a | 16'h8000);
  endfunction

  // Memory: answers a request seen in cycle N during cycle N+lat.
  always @(negedge clk) begin
    imem_valid = 1'b0;
    imem_err   = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          imem_valid = 1'b1;
          imem_data  = word_at(paddr);
          imem_err   = (paddr == err_addr);
        end
      end
      if (imem_req) begin
        pend  = lat;
        paddr = imem_addr;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (imem_req) rq.push_back(imem_addr);
      if (instr_valid && !stall && !redirect)
        gq.push_back({instr, pc_plus2});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rq_at(input int i);
    if (i >= 0 && i < rq.size()) return rq[i];
    return 16'hDEAD;
  endfunction

  function automatic logic [31:0] gq_at(input int i);
    if (i >= 0 && i < gq.size()) return gq[i];
    return 32'hDEADDEAD;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_reset();
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    cyc(2);
  endtask

  task automatic do_redirect(input logic [15:0] tgt);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = tgt;
    @(negedge clk);
    redirect    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g0;
    int r0;
    int r1;
    logic [15:0] a;
    logic [31:0] e;

    // reset values and streaming at latency 1
    lat = 1;
    hold_reset();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 16'h0800);
    chk("rst_pcp2", pc_plus2, 16'h0002);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    g0 = gq.size();
    r0 = rq.size();
    rst_n = 1'b1;
    cyc(1);
    chk("s_req1", imem_req, 1);
    chk("s_addr1", imem_addr, 16'h0000);
    chk("s_val1", instr_valid, 0);
    cyc(1);
    chk("s_req2", imem_req, 0);
    chk("s_val2", instr_valid, 0);
    cyc(1);
    chk("s_val3", instr_valid, 1);
    chk("s_instr3", instr, 16'h8000);
    chk("s_pcp2_3", pc_plus2, 16'h0002);
    chk("s_req3", imem_req, 1);
    chk("s_addr3", imem_addr, 16'h0002);
    cyc(14);
    for (int i = 0; i < 5; i++) begin
      a = 16'(2 * i);
      chk("s_reqseq", rq_at(r0 + i), a);
      chk("s_popseq", gq_at(g0 + i), {a | 16'h8000, a + 16'd2});
    end

    // backpressure with a full two-entry buffer
    hold_reset();
    stall = 1'b1;
    g0 = gq.size();
    r0 = rq.size();
    rst_n = 1'b1;
    cyc(6);
    chk("bp_val", instr_valid, 1);
    chk("bp_reqs", rq.size() - r0, 2);
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("bp_noreq", imem_req, 0);
      chk("bp_hold_i", instr, 16'h8000);
      chk("bp_hold_p", pc_plus2, 16'h0002);
    end
    stall = 1'b0;
    cyc(16);
    for (int i = 0; i < 6; i++) begin
      a = 16'(2 * i);
      chk("bp_order", gq_at(g0 + i), {a | 16'h8000, a + 16'd2});
    end

    // redirect while a latency-3 read is in flight
    hold_reset();
    lat = 3;
    g0 = gq.size();
    rst_n = 1'b1;
    cyc(1);
    chk("rd_req0", imem_addr, 16'h0000);
    cyc(1);
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    cyc(1);
    redirect = 1'b0;
    chk("rd_flush", instr_valid, 0);
    chk("rd_noreq3", imem_req, 0);
    cyc(1);
    chk("rd_noreq4", imem_req, 0);
    cyc(1);
    chk("rd_req5", imem_req, 1);
    chk("rd_addr5", imem_addr, 16'h0040);
    cyc(3);
    chk("rd_val8", instr_valid, 0);
    cyc(1);
    chk("rd_val9", instr_valid, 1);
    chk("rd_pcp2", pc_plus2, 16'h0042);
    chk("rd_instr", instr, 16'h8040);
    cyc(1);
    chk("rd_first", gq_at(g0), 32'h8040_0042);
    chk("rd_err", err, 0);

    // HALT at 0006 then resume by redirect
    hold_reset();
    lat = 1;
    halt_addr = 16'h0006;
    g0 = gq.size();
    r0 = rq.size();
    rst_n = 1'b1;
    cyc(20);
    chk("h_halted", halted, 1);
    chk("h_nreq", rq.size() - r0, 4);
    chk("h_lastreq", rq_at(r0 + 3), 16'h0006);
    chk("h_npop", gq.size() - g0, 4);
    for (int i = 0; i < 4; i++) begin
      a = 16'(2 * i);
      e = (i == 3) ? 32'h0000_0008 : {a | 16'h8000, a + 16'd2};
      chk("h_pops", gq_at(g0 + i), e);
    end
    chk("h_empty", instr_valid, 0);
    do_redirect(16'h0010);
    chk("h_resume", halted, 0);
    r1 = rq.size();
    cyc(3);
    chk("h_req10", rq_at(r1), 16'h0010);

    // wrap past FFFE and misaligned redirect target
    do_redirect(16'hFFFE);
    r1 = rq.size();
    cyc(6);
    chk("w_ffff", rq_at(r1), 16'hFFFE);
    chk("w_0000", rq_at(r1 + 1), 16'h0000);
    chk("w_err0", err, 0);
    do_redirect(16'h0013);
    r1 = rq.size();
    chk("w_err1", err, 1);
    cyc(4);
    chk("w_req12", rq_at(r1), 16'h0012);

    // faulted response: word still delivered, err sticky
    hold_reset();
    halt_addr = 16'hFFFF;
    err_addr  = 16'h0004;
    chk("e_rst", err, 0);
    g0 = gq.size();
    rst_n = 1'b1;
    cyc(4);
    chk("e_before", err, 0);
    cyc(8);
    chk("e_set", err, 1);
    chk("e_word", gq_at(g0 + 2), 32'h8004_0006);
    cyc(5);
    chk("e_sticky", err, 1);
    rst_n = 1'b0;
    #1;
    chk("e_clear", err, 0);
    err_addr = 16'hFFFF;

    // async reset with a response arriving, late strobe after
    hold_reset();
    stall = 1'b1;
    rst_n = 1'b1;
    cyc(3);
    chk("a_val3", instr_valid, 1);
    cyc(1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("a_val", instr_valid, 0);
    chk("a_instr", instr, 16'h0800);
    chk("a_pcp2", pc_plus2, 16'h0002);
    chk("a_req", imem_req, 0);
    chk("a_err0", err, 0);
    #2;
    rst_n = 1'b1;
    cyc(1);
    chk("a_err1", err, 1);
    chk("a_noenq", instr_valid, 0);
    chk("a_req1", imem_req, 1);
    chk("a_addr1", imem_addr, 16'h0000);
    stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end that produces the instruction stream the decode stage consumes.
- Holds the PC and issues word-aligned reads to the instruction memory.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/stall handshake.
- Squashes wrong-path fetches on a branch/jump redirect and stops fetching after a HALT.

Parameters:
BUF_DEPTH, 2, instruction buffer entries (power of two, >=2)
RESET_PC, 16'h0000, PC value loaded at reset
NOP_INSTR, 16'h0800, value driven on instr when no valid entry

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
imem_req  output  1  read request to instruction memory
imem_addr  output  16  read address (bit 0 always 0)
imem_valid  input  1  response strobe, >=1 cycle after accepted req
imem_data  input  16  instruction word, qualified by imem_valid
imem_err  input  1  memory fault, qualified by imem_valid
stall  input  1  decode/hazard unit cannot accept instr this cycle
redirect  input  1  taken branch/jump/JR, resolved downstream
redirect_pc  input  16  new fetch target, qualified by redirect
instr  output  16  head-of-buffer instruction to decode
pc_plus2  output  16  address of instr + 2, feeds link/branch adders
instr_valid  output  1  instr/pc_plus2 meaningful
halted  output  1  HALT fetched, fetch stopped
err  output  1  sticky fault flag

Behaviour:
- Reset (rst_n low, async):
  - pc=RESET_PC; buffer empty; outstanding=0; drop=0; state=FETCH.
  - imem_req=0, instr_valid=0, instr=NOP_INSTR, pc_plus2=RESET_PC+2, halted=0, err=0.
  - Reset asserted mid-transaction abandons any in-flight response.
- At most one outstanding memory request. imem_req is a one-cycle pulse with imem_addr=pc.
- Issue condition: state==FETCH, no outstanding request, and (occupancy + outstanding) < BUF_DEPTH. On issue: outstanding=1, issue_pc=pc, pc<=pc+2 (16-bit wrap, FFFE->0000).
- Response, imem_valid with outstanding=1:
  - outstanding clears.
  - drop=1: data discarded, drop clears.
  - drop=0: enqueue {imem_data, issue_pc+2}.
  - An enqueue into an empty buffer is visible on instr the next cycle (fetch-to-decode latency = memory latency + 1).
- Handshake: instr_valid = buffer non-empty. Head pops when instr_valid && !stall. instr and pc_plus2 are held stable while stalled. With the buffer empty, instr=NOP_INSTR.
- Same-cycle pop and enqueue on a full buffer is legal; occupancy is unchanged.
- HALT detection: an enqueued word with opcode bits[15:11]==5'b00000 moves state to HALTED and sets halted=1.
  - No further requests are issued.
  - Buffered entries, including the HALT, keep draining to decode.
  - HALTED is left only by redirect or reset.
- redirect has highest priority, same cycle:
  - buffer flushed, so instr_valid=0 next cycle;
  - pc<=redirect_pc; state=FETCH; halted=0;
  - if a request is outstanding and its response is not arriving this cycle, drop=1.
  - Any imem_valid in the redirect cycle is discarded.
  - A pop requested in the redirect cycle is ignored.
  - The first new request issues the cycle after redirect, or the cycle after the dropped response returns.
- States: FETCH (issuing), HALTED (idle). WAIT is not a separate state; it is the outstanding flag.
- err is set (sticky until reset) on any of:
  - imem_valid && imem_err;
  - imem_valid with no outstanding request;
  - redirect with redirect_pc[0]=1. The target is still loaded with bit 0 forced to 0.
- A faulted response is still enqueued, so decode sees the word and err together.

Decomposition:
- Shared package: NOP_INSTR, HALT_OPCODE 5'b00000, instruction/address width 16, fetch state encoding.
- One natural sub-module: fetch_fifo. It is a parameterised BUF_DEPTH FIFO of {instr, pc_plus2} with push/pop/flush, full/empty and occupancy outputs. PC/issue/drop control stays in fetch_unit.

Test Plan:
- Streaming: reset, RESET_PC=0, memory latency 1, stall=0 -> addresses 0000,0002,0004… requested in order; instr_valid first high 2 cycles after the first req; pc_plus2 = 0002,0004,…
- Backpressure: stall=1 for 6 cycles after 2 instructions are fetched -> buffer full (2 entries), no imem_req while full; instr/pc_plus2 held; release -> order preserved, no loss or duplication.
- Redirect with in-flight read: latency 3, redirect to 16'h0040 one cycle after a req -> stale response dropped, buffer empty next cycle, next imem_addr=0040, first valid pc_plus2=0042.
- HALT: word 16'h0000 at address 0006 -> no req after the one for 0006; halted=1; 0000..0006 all delivered; a later redirect to 0010 resumes fetch with halted=0.
- Wrap and errors: redirect_pc=FFFE -> next addresses FFFE, 0000. redirect_pc=0013 -> err=1 and fetch from 0012. imem_err with imem_valid -> err stays 1 until rst_n low.
- Async reset mid-fetch: drop rst_n between clock edges while a req is outstanding -> all outputs return to reset values immediately; the late imem_valid after release sets err=1.
